imsic_intp_file: RTL
====================

Name: imsic_intp_file

Overview:
One IMSIC interrupt file, sitting directly downstream of the IMSIC register map. It consumes one lane of the setipnum/setipnum_we pair and holds the eip (pending) and eie (enable) arrays plus the eidelivery and eithreshold registers. A sequential word-by-word scanner produces the top enabled pending identity (topei) and the interrupt line to the hart. It also performs the claim operation.

Parameters:
NR_SRC, 64, number of identities including reserved ID 0; a multiple of 32, at most 2048.
NR_SRC_LEN, 32, width of the setipnum input.
NR_WORDS, NR_SRC/32, derived; number of 32-bit eip/eie words.
ID_W, $clog2(NR_SRC), derived; identity width.

Ports:
i_clk  in  1  clock
ni_rst  in  1  asynchronous active-low reset
i_setipnum  in  NR_SRC_LEN  identity to set pending
i_setipnum_we  in  1  one-cycle strobe qualifying i_setipnum
i_reg_sel  in  8  indirect register select: 0x70 eidelivery, 0x72 eithreshold, 0x80+k eip k, 0xC0+k eie k
i_reg_we  in  1  write strobe for i_reg_sel
i_reg_wdata  in  32  write data
o_reg_rdata  out  32  combinational read data for i_reg_sel
i_claim  in  1  one-cycle claim strobe (topei write/swap)
o_topei  out  ID_W  registered top identity; 0 = none
o_xeip  out  1  interrupt to hart

Behaviour:
- Reset (async, ni_rst=0): eip, eie, eidelivery, eithreshold, o_topei, dirty and FSM are all cleared; FSM goes to IDLE, word index 0. Reset mid-scan aborts the scan.
- setipnum: with i_setipnum_we=1 and 1 <= i_setipnum <= NR_SRC-1, set eip[i_setipnum] at the next edge. Values 0 and >= NR_SRC are ignored silently.
- Register writes:
  - eidelivery: only bit0 is stored.
  - eithreshold: bits[ID_W-1:0] are stored.
  - eip k / eie k: full word is stored.
  - Bit 0 of eip0 and eie0 is hardwired 0.
  - Selects with k >= NR_WORDS, and all unmapped selects, are write-ignored and read 0.
- Reads: o_reg_rdata is a pure function of i_reg_sel and current register state. No read side effects.
- Claim: i_claim=1 with o_topei!=0 clears eip[o_topei]. With o_topei==0 it does nothing. o_topei itself is updated only by the scanner.
- Same-cycle priority for the same eip bit (lowest to highest): register write, then claim clear, then setipnum set. Set wins over both.
- dirty flag: set at the edge ending any cycle with a valid setipnum, any register write to a mapped register, or an effective claim.
- FSM, states IDLE and SCAN:
  - IDLE with dirty=1: clear dirty, load w=0, go to SCAN.
  - SCAN, each cycle:
    - m = eip[w] & eie[w].
    - m != 0: cand = w*32 + index of lowest set bit of m. o_topei <= (eithreshold==0 || cand < eithreshold) ? cand : 0. Go to IDLE. Lowest ID has highest priority, so a failing candidate means no candidate passes.
    - m == 0 and w == NR_WORDS-1: o_topei <= 0, go to IDLE.
    - Otherwise: w <= w+1.
  - Events during SCAN set dirty again; the current scan completes and is followed by a full rescan. There is no restart mid-scan.
- Latency: an event in cycle 0 whose winner lies in word w makes o_topei valid in cycle 3+w. Worst case is 2+NR_WORDS cycles, plus one extra full scan if an event lands during a scan.
- o_xeip = eidelivery[0] & (o_topei != 0), combinational from registers.
- Between an event and scan completion, o_topei holds its previous value. A claim of a stale ID clears that bit if it is set, otherwise has no effect.

Test Plan:
1. Reset: assert ni_rst=0 mid-SCAN -> o_topei=0, o_xeip=0, every o_reg_rdata=0, FSM in IDLE after release.
2. Write eidelivery=1, eie0=0xFFFF_FFFE; setipnum=5 in cycle 0 -> o_topei=5 and o_xeip=1 in cycle 3; eip0 reads 0x0000_0020.
3. eie1=0xFFFF_FFFF; setipnum 40 then 5 -> o_topei=5. Pulse i_claim -> eip0 reads 0; o_topei=40 two cycles after the rescan starts (word 1); claim again -> o_topei=0, o_xeip=0.
4. Pending 5 enabled: eithreshold=5 -> o_topei=0, o_xeip=0; eithreshold=6 -> o_topei=5; eithreshold=0 -> o_topei=5; eidelivery=0 -> o_xeip=0 while o_topei=5.
5. setipnum=0, setipnum=64, setipnum=0xFFFF_FFFF, write eip0=0x1 -> all eip read 0, o_topei stays 0; read select 0xC2 (k>=NR_WORDS) -> 0.
6. o_topei=5 with i_claim and setipnum=5 in the same cycle -> eip0 bit5 stays 1, o_topei=5. Register write eip0=0 together with setipnum=5 -> bit5 ends 1.

Source files
------------

// File: rtl/imsic_intp_file_if.sv
// Register-map-side bundle for one IMSIC interrupt file: setipnum lane,
// indirect register access, claim strobe and the top-identity outputs.
interface imsic_intp_file_if #(
  parameter int NR_SRC     = 64,
  parameter int NR_SRC_LEN = 32
);
  localparam int ID_W = $clog2(NR_SRC);

  logic [NR_SRC_LEN-1:0] setipnum;
  logic                  setipnum_we;
  logic [7:0]            reg_sel;
  logic                  reg_we;
  logic [31:0]           reg_wdata;
  logic [31:0]           reg_rdata;
  logic                  claim;
  logic [ID_W-1:0]       topei;
  logic                  xeip;

  modport master (
    output setipnum, setipnum_we, reg_sel, reg_we, reg_wdata, claim,
    input  reg_rdata, topei, xeip
  );

  modport slave (
    input  setipnum, setipnum_we, reg_sel, reg_we, reg_wdata, claim,
    output reg_rdata, topei, xeip
  );
endinterface

// File: rtl/imsic_intp_file.sv
// IMSIC interrupt file: eip/eie arrays, eidelivery/eithreshold, and a
// word-serial scanner that registers the lowest enabled pending identity.
module imsic_intp_file #(
  parameter int NR_SRC     = 64,
  parameter int NR_SRC_LEN = 32
) (
  input  logic               i_clk,
  input  logic               ni_rst,
  imsic_intp_file_if.slave   bus
);
  localparam int NR_WORDS = NR_SRC / 32;
  localparam int ID_W     = $clog2(NR_SRC);
  localparam int W_W      = (NR_WORDS > 1) ? $clog2(NR_WORDS) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state, state_nxt;
  logic [W_W-1:0]  w, w_nxt;
  logic [31:0]     eip [NR_WORDS];
  logic [31:0]     eie [NR_WORDS];
  logic [31:0]     eip_nxt [NR_WORDS];
  logic [31:0]     eie_nxt [NR_WORDS];
  logic            eidelivery;
  logic [ID_W-1:0] eithreshold;
  logic [ID_W-1:0] topei, topei_nxt;
  logic            dirty, dirty_nxt;

  // Indirect register decode
  logic [5:0]     sel_k;
  logic [W_W-1:0] sel_w;
  logic           sel_deliv, sel_thresh, sel_eip, sel_eie, wr_hit;

  assign sel_k      = bus.reg_sel[5:0];
  assign sel_w      = W_W'(sel_k);
  assign sel_deliv  = (bus.reg_sel == 8'h70);
  assign sel_thresh = (bus.reg_sel == 8'h72);
  assign sel_eip    = (bus.reg_sel[7:6] == 2'b10) && ({26'b0, sel_k} < 32'(NR_WORDS));
  assign sel_eie    = (bus.reg_sel[7:6] == 2'b11) && ({26'b0, sel_k} < 32'(NR_WORDS));
  assign wr_hit     = bus.reg_we && (sel_deliv || sel_thresh || sel_eip || sel_eie);

  // Pending-bit sources: setipnum lane and claim of the current topei
  logic           set_ok, claim_ok, ev;
  logic [W_W-1:0] set_w, clm_w;
  logic [4:0]     set_b, clm_b;

  assign set_ok   = bus.setipnum_we && (bus.setipnum != '0) &&
                    (bus.setipnum < NR_SRC_LEN'(NR_SRC));
  assign set_w    = W_W'(bus.setipnum >> 5);
  assign set_b    = bus.setipnum[4:0];
  assign claim_ok = bus.claim && (topei != '0);
  assign clm_w    = W_W'(topei >> 5);
  assign clm_b    = topei[4:0];
  assign ev       = set_ok || wr_hit || claim_ok;

  // Later assignments win: register write < claim clear < setipnum set.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    eip_nxt = eip;
    eie_nxt = eie;
    if (bus.reg_we && sel_eip) eip_nxt[sel_w] = bus.reg_wdata;
    if (bus.reg_we && sel_eie) eie_nxt[sel_w] = bus.reg_wdata;
    if (claim_ok) eip_nxt[clm_w][clm_b] = 1'b0;
    if (set_ok)   eip_nxt[set_w][set_b] = 1'b1;
    eip_nxt[0][0] = 1'b0;
    eie_nxt[0][0] = 1'b0;
  end

  always_comb begin
    bus.reg_rdata = '0;
    if (sel_deliv)       bus.reg_rdata = {31'b0, eidelivery};
    else if (sel_thresh) bus.reg_rdata = 32'(eithreshold);
    else if (sel_eip)    bus.reg_rdata = eip[sel_w];
    else if (sel_eie)    bus.reg_rdata = eie[sel_w];
  end

  // Lowest set bit of the current word's enabled-pending mask
  logic [31:0]     m;
  logic [4:0]      lsb;
  logic [ID_W-1:0] cand;

  always_comb begin
    m   = eip[w] & eie[w];
    lsb = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) lsb = 5'(i);
    end
    cand = ID_W'({w, lsb});
  end

  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    topei_nxt = topei;
    dirty_nxt = dirty;
    case (state)
      IDLE: if (dirty) begin
        dirty_nxt = 1'b0;
        w_nxt     = '0;
        state_nxt = SCAN;
      end
      SCAN: begin
        if (m != '0) begin
          // The lowest candidate failing the threshold means none can pass.
          topei_nxt = (eithreshold == '0 || cand < eithreshold) ? cand : '0;
          state_nxt = IDLE;
        end else if (w == W_W'(NR_WORDS - 1)) begin
          topei_nxt = '0;
          state_nxt = IDLE;
        end else begin
          w_nxt = w + W_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (ev) dirty_nxt = 1'b1;
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state       <= IDLE;
      w           <= '0;
      topei       <= '0;
      dirty       <= 1'b0;
      eidelivery  <= 1'b0;
      eithreshold <= '0;
      // NOTE: the pending/enable arrays are architectural state with a defined reset value, so they are reset like any other register.
      for (int k = 0; k < NR_WORDS; k++) begin
        eip[k] <= '0;
        eie[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      w     <= w_nxt;
      topei <= topei_nxt;
      dirty <= dirty_nxt;
      eip   <= eip_nxt;
      eie   <= eie_nxt;
      if (bus.reg_we && sel_deliv)  eidelivery  <= bus.reg_wdata[0];
      if (bus.reg_we && sel_thresh) eithreshold <= bus.reg_wdata[ID_W-1:0];
    end
  end

  assign bus.topei = topei;
  assign bus.xeip  = eidelivery && (topei != '0);
endmodule
